// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter width and lock-state encoding
// used by both the VGA timing generator and the sync recovery block.
package vga_timing_pkg;

  localparam int CNT_W = 13;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FPORCH  = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BPORCH  = 48;
  localparam int VGA_H_FP_END  = VGA_H_VISIBLE + VGA_H_FPORCH;
  localparam int VGA_H_TOTAL   = VGA_H_FP_END + VGA_H_SYNC + VGA_H_BPORCH;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FPORCH  = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BPORCH  = 33;
  localparam int VGA_V_FP_END  = VGA_V_VISIBLE + VGA_V_FPORCH;
  localparam int VGA_V_TOTAL   = VGA_V_FP_END + VGA_V_SYNC + VGA_V_BPORCH;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } sync_state_e;

  // Wrapping increment shared by the horizontal and vertical counters.
  function automatic cnt_t cnt_step(input cnt_t cur, input cnt_t last);
    return (cur == last) ? '0 : cur + cnt_t'(1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one incoming sync pin and reports its inactive-to-active edge,
// both as a look-ahead (for loading counters) and aligned with the register.
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic level_o,
  output logic edge_next_o,
  output logic edge_o
);

  logic sample_q;
  logic edge_q;
  logic pin_active;
  logic reg_active;

  assign pin_active = sync_i ^ ACTIVE_LOW;
  assign reg_active = sample_q ^ ACTIVE_LOW;

  // High in the cycle before the registered level first shows active.
  assign edge_next_o = pin_active & ~reg_active;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sample_q <= ACTIVE_LOW;
      edge_q   <= 1'b0;
    end else begin
      sample_q <= sync_i;
      edge_q   <= edge_next_o;
    end
  end

  assign level_o = sample_q;
  assign edge_o  = edge_q;

endmodule

// File: rtl/vga_sync_recover.sv
// Rebuilds hcnt/vcnt and the visible-area flag from an incoming hsync/vsync
// pair, and tracks whether the source timing is locked.
module vga_sync_recover
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE       = VGA_H_VISIBLE,
  parameter int H_FPORCH        = VGA_H_FPORCH,
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BPORCH        = VGA_H_BPORCH,
  parameter int V_VISIBLE       = VGA_V_VISIBLE,
  parameter int V_FPORCH        = VGA_V_FPORCH,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BPORCH        = VGA_V_BPORCH,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2,
  parameter int TIMEOUT_LINES   = 2
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [CNT_W-1:0]  hcnt,
  output logic [CNT_W-1:0]  vcnt,
  output logic              visible_area,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_start,
  output logic              locked,
  output logic [7:0]        err_count,
  output sync_state_e       state_dbg
);

  localparam int H_FP_END = H_VISIBLE + H_FPORCH;
  localparam int H_TOTAL  = H_FP_END + H_SYNC + H_BPORCH;
  localparam int V_FP_END = V_VISIBLE + V_FPORCH;
  localparam int V_TOTAL  = V_FP_END + V_SYNC + V_BPORCH;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_LOAD = cnt_t'(H_FP_END);
  localparam cnt_t V_LOAD = cnt_t'(V_FP_END);
  localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);

  localparam int TO_LIMIT = TIMEOUT_LINES * H_TOTAL;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int GOOD_W   = $clog2(LOCK_FRAMES + 1);

  localparam logic [TO_W-1:0]   TO_MAX      = TO_W'(TO_LIMIT);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_FRAMES);
  localparam bit                ACT_LOW     = (SYNC_ACTIVE_LOW != 0);

  logic h_edge_next, h_edge;
  logic v_edge_next, v_edge;

  cnt_t hcnt_q, hcnt_d, h_free;
  cnt_t vcnt_q, vcnt_d, v_free;
  logic mis_q, mis_d;

  sync_state_e       state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic              clean_q, clean_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              timeout;
  logic [7:0]        err_q, err_d;
  logic              visible_q, visible_d;
  logic              fs_q, fs_d;

  sync_edge_detect #(.ACTIVE_LOW(ACT_LOW)) u_hsync_det (
    .clk_i       (pixel_clk),
    .rst_ni      (rst),
    .sync_i      (hsync_in),
    .level_o     (hsync_out),
    .edge_next_o (h_edge_next),
    .edge_o      (h_edge)
  );

  sync_edge_detect #(.ACTIVE_LOW(ACT_LOW)) u_vsync_det (
    .clk_i       (pixel_clk),
    .rst_ni      (rst),
    .sync_i      (vsync_in),
    .level_o     (vsync_out),
    .edge_next_o (v_edge_next),
    .edge_o      (v_edge)
  );

  // Counters load on the look-ahead edge so the loaded value appears in the
  // same cycle the registered sync first shows active. The mismatch verdict
  // is registered so the FSM consumes it alongside the aligned edge pulse.
  always_comb begin
    h_free = cnt_step(hcnt_q, H_LAST);
    v_free = (hcnt_q == H_LAST) ? cnt_step(vcnt_q, V_LAST) : vcnt_q;
    hcnt_d = h_edge_next ? H_LOAD : h_free;
    vcnt_d = v_edge_next ? V_LOAD : v_free;
    mis_d  = (h_edge_next && (h_free != H_LOAD)) ||
             (v_edge_next && (v_free != V_LOAD));
  end

  assign timeout  = (to_q == TO_MAX);
  assign good_inc = good_q + GOOD_W'(1);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    clean_d = clean_q;
    err_d   = err_q;
    to_d    = to_q;

    if (h_edge) begin
      to_d = '0;
    end else if (!timeout) begin
      to_d = to_q + TO_W'(1);
    end

    unique case (state_q)
      UNLOCKED: begin
        if (v_edge) begin
          state_d = ACQUIRE;
          good_d  = '0;
          clean_d = 1'b1;
        end
      end
      ACQUIRE: begin
        if (v_edge) begin
          // Each vsync edge closes one frame interval and opens the next.
          clean_d = 1'b1;
          if (mis_q) begin
            good_d = '0;
          end else if (clean_q) begin
            good_d = good_inc;
            if (good_inc == GOOD_TARGET) begin
              state_d = LOCKED;
            end
          end
        end else if (mis_q) begin
          good_d  = '0;
          clean_d = 1'b0;
        end
      end
      LOCKED: begin
        if (mis_q) begin
          state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase

    if (timeout) begin
      state_d = UNLOCKED;
    end

    if (mis_q && (state_q != UNLOCKED) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end

    visible_d = (state_d == LOCKED) && (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
    fs_d      = (state_d == LOCKED) && (hcnt_d == '0) && (vcnt_d == '0);
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      mis_q     <= 1'b0;
      state_q   <= UNLOCKED;
      good_q    <= '0;
      clean_q   <= 1'b0;
      to_q      <= '0;
      err_q     <= '0;
      visible_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      mis_q     <= mis_d;
      state_q   <= state_d;
      good_q    <= good_d;
      clean_q   <= clean_d;
      to_q      <= to_d;
      err_q     <= err_d;
      visible_q <= visible_d;
      fs_q      <= fs_d;
    end
  end

  assign hcnt         = hcnt_q;
  assign vcnt         = vcnt_q;
  assign locked       = (state_q == LOCKED);
  assign visible_area = visible_q;
  assign frame_start  = fs_q;
  assign err_count    = err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vga_sync_recover.sv
// Directed bench for vga_sync_recover on a shrunken 16x9 raster (8x4 visible)
// driven by a small behavioural timing generator.
module tb_vga_sync_recover;
  import vga_timing_pkg::*;

  localparam int HV = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VV = 4, VFP = 2, VS = 1, VBP = 2;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int HFE = HV + HFP;
  localparam int VFE = VV + VFP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, gen_rst;
  int   cyc;
  int   src_htot;
  int   gen_h, gen_v;
  logic hs_gen, vs_gen, hs_act;
  logic [2:0] hs_hist;
  logic dly, hold;

  logic [CNT_W-1:0] hcnt_n, vcnt_n, hcnt_p, vcnt_p;
  logic vis_n, hso_n, vso_n, fs_n, lock_n;
  logic vis_p, hso_p, vso_p, fs_p, lock_p;
  logic [7:0] err_n, err_p;
  sync_state_e st_n, st_p;

  int n_cmp = 0;
  int n_fail = 0;

  // Generator: counters, syncs decoded combinationally from them.
  always @(posedge clk) begin
    if (!gen_rst) begin
      cyc   <= 0;
      gen_h <= 0;
      gen_v <= 0;
    end else begin
      cyc <= cyc + 1;
      if (gen_h == src_htot - 1) begin
        gen_h <= 0;
        gen_v <= (gen_v == VT - 1) ? 0 : gen_v + 1;
      end else begin
        gen_h <= gen_h + 1;
      end
    end
    hs_hist <= {hs_hist[1:0], hs_gen};
  end

  assign hs_gen = (gen_h >= HFE) && (gen_h < HFE + HS);
  assign vs_gen = (gen_v >= VFE) && (gen_v < VFE + VS);
  assign hs_act = hold ? 1'b0 : (dly ? hs_hist[2] : hs_gen);

  vga_sync_recover #(
    .H_VISIBLE(HV), .H_FPORCH(HFP), .H_SYNC(HS), .H_BPORCH(HBP),
    .V_VISIBLE(VV), .V_FPORCH(VFP), .V_SYNC(VS), .V_BPORCH(VBP),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2), .TIMEOUT_LINES(2)
  ) dut_n (
    .pixel_clk(clk), .rst(rst), .hsync_in(~hs_act), .vsync_in(~vs_gen),
    .hcnt(hcnt_n), .vcnt(vcnt_n), .visible_area(vis_n),
    .hsync_out(hso_n), .vsync_out(vso_n), .frame_start(fs_n),
    .locked(lock_n), .err_count(err_n), .state_dbg(st_n)
  );

  vga_sync_recover #(
    .H_VISIBLE(HV), .H_FPORCH(HFP), .H_SYNC(HS), .H_BPORCH(HBP),
    .V_VISIBLE(VV), .V_FPORCH(VFP), .V_SYNC(VS), .V_BPORCH(VBP),
    .SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(2), .TIMEOUT_LINES(2)
  ) dut_p (
    .pixel_clk(clk), .rst(gen_rst), .hsync_in(hs_act), .vsync_in(vs_gen),
    .hcnt(hcnt_p), .vcnt(vcnt_p), .visible_area(vis_p),
    .hsync_out(hso_p), .vsync_out(vso_p), .frame_start(fs_p),
    .locked(lock_p), .err_count(err_p), .state_dbg(st_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge of generator cycle t.
  task automatic goto(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_h, exp_v, fs_seen;
    logic ever_locked;
    rst = 1'b0; gen_rst = 1'b0; dly = 1'b0; hold = 1'b0; src_htot = HT;
    hs_hist = 3'b000;
    repeat (3) @(negedge clk);

    chk("rst_hcnt", hcnt_n, 0);
    chk("rst_vcnt", vcnt_n, 0);
    chk("rst_locked", lock_n, 0);
    chk("rst_visible", vis_n, 0);
    chk("rst_frame_start", fs_n, 0);
    chk("rst_err", err_n, 0);
    chk("rst_hsync_out_n", hso_n, 1);
    chk("rst_vsync_out_n", vso_n, 1);
    chk("rst_hsync_out_p", hso_p, 0);
    chk("rst_state", st_n, UNLOCKED);
    rst = 1'b1; gen_rst = 1'b1;

    // Initial acquisition: vsync edges at cycles 97, 241, 385.
    goto(97);  chk("acq_state_at_edge1", st_n, UNLOCKED);
    goto(98);  chk("acq_state_after_edge1", st_n, ACQUIRE);
    goto(385); chk("lock_before_n", lock_n, 0); chk("lock_before_p", lock_p, 0);
    goto(386); chk("lock_after_n", lock_n, 1); chk("lock_after_p", lock_p, 1);

    fs_seen = 0;
    for (int t = 400; t < 400 + 2 * HT * VT; t++) begin
      goto(t);
      exp_h = (t - 1) % HT;
      exp_v = ((t - 1) / HT) % VT;
      chk("scan_hcnt_n", hcnt_n, exp_h);
      chk("scan_vcnt_n", vcnt_n, exp_v);
      chk("scan_vis_n", vis_n, (exp_h < HV) && (exp_v < VV));
      chk("scan_fs_n", fs_n, (exp_h == 0) && (exp_v == 0));
      chk("scan_hcnt_p", hcnt_p, exp_h);
      chk("scan_vcnt_p", vcnt_p, exp_v);
      chk("scan_vis_p", vis_p, (exp_h < HV) && (exp_v < VV));
      fs_seen += int'(fs_n);
    end
    chk("frame_start_count", fs_seen, 2);
    chk("scan_err", err_n, 0);

    // One hsync pulse delayed by 3 cycles (line 1 of the frame at 720).
    goto(736); dly = 1'b1;
    goto(750); chk("late_edge_hcnt", hcnt_n, HFE); chk("late_edge_locked", lock_n, 1);
    chk("late_edge_err", err_n, 0);
    goto(751); chk("late_unlock", lock_n, 0); chk("late_err", err_n, 1);
    goto(752); dly = 1'b0;
    goto(1105); chk("relock_before", lock_n, 0);
    goto(1106); chk("relock_after", lock_n, 1); chk("relock_err", err_n, 1);
    goto(1200); chk("relock_hcnt", hcnt_n, 1199 % HT);

    // Hsync held inactive from cycle 1296; last edge at 1291.
    goto(1296); hold = 1'b1;
    goto(1324); chk("timeout_before", lock_n, 1);
    goto(1325); chk("timeout_after", lock_n, 0);
    goto(1400); chk("timeout_state", st_n, UNLOCKED);
    goto(1441); chk("timeout_hcnt", hcnt_n, 0); chk("timeout_vcnt", vcnt_n, 0);
    chk("timeout_visible", vis_n, 0); chk("timeout_fs", fs_n, 0);
    goto(1584); hold = 1'b0;
    goto(1969); chk("restore_before", lock_n, 0);
    goto(1970); chk("restore_after", lock_n, 1); chk("restore_err", err_n, 1);

    // One-cycle reset mid-frame while locked.
    goto(2000); rst = 1'b0;
    goto(2001);
    chk("mid_rst_hcnt", hcnt_n, 0);
    chk("mid_rst_vcnt", vcnt_n, 0);
    chk("mid_rst_locked", lock_n, 0);
    chk("mid_rst_err", err_n, 0);
    chk("mid_rst_visible", vis_n, 0);
    chk("mid_rst_fs", fs_n, 0);
    chk("mid_rst_vsync_out", vso_n, 1);
    rst = 1'b1;
    goto(2401); chk("post_rst_lock_before", lock_n, 0);
    goto(2402); chk("post_rst_lock_after", lock_n, 1); chk("post_rst_err", err_n, 0);

    // Source with one pixel too few per line: never locks, err saturates.
    @(negedge clk);
    rst = 1'b0; gen_rst = 1'b0; src_htot = HT - 1;
    @(negedge clk);
    rst = 1'b1; gen_rst = 1'b1;
    ever_locked = 1'b0;
    for (int t = 1; t <= 5000; t++) begin
      goto(t);
      if (lock_n) ever_locked = 1'b1;
      if (t == 91)  chk("short_err_unlocked", err_n, 0);
      if (t == 92)  chk("short_state_acq", st_n, ACQUIRE);
      if (t == 101) chk("short_err_pre", err_n, 0);
      if (t == 102) chk("short_err_first", err_n, 1);
    end
    chk("short_never_locked", ever_locked, 0);
    chk("short_err_saturated", err_n, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
